// File: rtl/melody_sequencer.sv
// Melody sequencer: walks a fixed 16-step song table on beat-clock rises and
// drives a square-wave tone at the current note's pitch.
module melody_sequencer #(
   parameter int SONG_LEN   = 16,
   parameter int TONE_SHIFT = 0
) (
   input  logic       clock_i,
   input  logic       reset_ni,
   input  logic       beat_clk_i,
   input  logic       start_i,
   input  logic       stop_i,
   input  logic       pause_i,
   input  logic       loop_en_i,
   output logic [3:0] note_idx_o,
   output logic [3:0] step_idx_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       audio_out_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PLAYING = 2'd1,
      PAUSED  = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [3:0] LAST_STEP = 4'(SONG_LEN - 1);

   // Scale up C4..C5 over steps 0-7, back down over steps 8-15.
   function automatic logic [3:0] song_note(input logic [3:0] step);
      return step[3] ? (4'd8 - {1'b0, step[2:0]}) : (step + 4'd1);
   endfunction

   function automatic logic [1:0] song_dur(input logic [3:0] step);
      return (step[2:0] == 3'd7) ? 2'd1 : 2'd0;
   endfunction

   function automatic logic [16:0] note_pitch(input logic [3:0] note);
      case (note)
         4'd1:    return 17'd95556;
         4'd2:    return 17'd85131;
         4'd3:    return 17'd75843;
         4'd4:    return 17'd71586;
         4'd5:    return 17'd63776;
         4'd6:    return 17'd56818;
         4'd7:    return 17'd50619;
         4'd8:    return 17'd47778;
         default: return 17'd0;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [3:0]  step_q, step_d;
   logic [3:0]  note_q, note_d;
   logic [1:0]  beat_cnt_q, beat_cnt_d;
   logic [16:0] tone_cnt_q, tone_cnt_d;
   logic        audio_q, audio_d;
   logic        s1_q, s2_q, s3_q;
   logic        beat_tick;
   logic [16:0] half_period;

   assign beat_tick   = s2_q & ~s3_q;
   assign half_period = note_pitch(note_q) >> TONE_SHIFT;

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      note_d     = note_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (!stop_i && start_i) begin
               state_d    = PLAYING;
               step_d     = 4'd0;
               beat_cnt_d = 2'd0;
               note_d     = song_note(4'd0);
            end
         end
         PLAYING: begin
            if (stop_i) begin
               state_d    = IDLE;
               step_d     = 4'd0;
               note_d     = 4'd0;
               beat_cnt_d = 2'd0;
            end else if (pause_i) begin
               state_d = PAUSED;
            end else if (beat_tick) begin
               if (beat_cnt_q < song_dur(step_q)) begin
                  beat_cnt_d = beat_cnt_q + 2'd1;
               end else begin
                  beat_cnt_d = 2'd0;
                  if (step_q < LAST_STEP) begin
                     step_d = step_q + 4'd1;
                     note_d = song_note(step_q + 4'd1);
                  end else if (loop_en_i) begin
                     step_d = 4'd0;
                     note_d = song_note(4'd0);
                  end else begin
                     state_d = DONE;
                     step_d  = 4'd0;
                     note_d  = 4'd0;
                  end
               end
            end
         end
         PAUSED: begin
            if (stop_i) begin
               state_d    = IDLE;
               step_d     = 4'd0;
               note_d     = 4'd0;
               beat_cnt_d = 2'd0;
            end else if (!pause_i) begin
               state_d = PLAYING;
            end
         end
         DONE: begin
            state_d    = IDLE;
            step_d     = 4'd0;
            note_d     = 4'd0;
            beat_cnt_d = 2'd0;
         end
         default: state_d = IDLE;
      endcase
   end

   // The tone restarts from a clean phase whenever the note or play state changes.
   always_comb begin
      tone_cnt_d = 17'd0;
      audio_d    = 1'b0;
      if ((state_q == PLAYING) && (state_d == PLAYING) && (note_d == note_q) &&
          (half_period != 17'd0)) begin
         if (tone_cnt_q >= half_period - 17'd1) begin
            tone_cnt_d = 17'd0;
            audio_d    = ~audio_q;
         end else begin
            tone_cnt_d = tone_cnt_q + 17'd1;
            audio_d    = audio_q;
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (!reset_ni) begin
         state_q    <= IDLE;
         step_q     <= 4'd0;
         note_q     <= 4'd0;
         beat_cnt_q <= 2'd0;
         tone_cnt_q <= 17'd0;
         audio_q    <= 1'b0;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         s3_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         note_q     <= note_d;
         beat_cnt_q <= beat_cnt_d;
         tone_cnt_q <= tone_cnt_d;
         audio_q    <= audio_d;
         s1_q       <= beat_clk_i;
         s2_q       <= s1_q;
         s3_q       <= s2_q;
      end
   end

   assign note_idx_o  = note_q;
   assign step_idx_o  = step_q;
   assign busy_o      = (state_q == PLAYING) || (state_q == PAUSED);
   assign done_o      = (state_q == DONE);
   assign audio_out_o = audio_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Randomised bench: a beat-level song model predicts output changes and the
// tone waveform; a monitor compares them against the sequencer cycle by cycle.
module tb_melody_sequencer;

   localparam int SONG_LEN   = 16;
   localparam int TONE_SHIFT = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       beat = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       pause = 1'b0;
   logic       loop_en = 1'b0;
   logic [3:0] note_o, step_o;
   logic       busy_o, done_o, audio_o;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   bit mon_en = 1'b0;

   melody_sequencer #(.SONG_LEN(SONG_LEN), .TONE_SHIFT(TONE_SHIFT)) dut (
      .clock_i(clk), .reset_ni(rst_n), .beat_clk_i(beat), .start_i(start),
      .stop_i(stop), .pause_i(pause), .loop_en_i(loop_en),
      .note_idx_o(note_o), .step_idx_o(step_o), .busy_o(busy_o),
      .done_o(done_o), .audio_out_o(audio_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int song_note [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 7, 6, 5, 4, 3, 2, 1};
   int song_beats[16] = '{1, 1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 1, 2};
   int pitch     [9]  = '{0, 95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778};

   typedef struct { int cyc; logic [3:0] step; logic [3:0] note; logic busy; logic done; } exp_t;
   typedef struct { int cyc; bit on; int hp; int t0; } tone_t;
   exp_t  sb_q[$];
   tone_t tl_q[$];

   // Song model: position, remaining beats on the current note, tone phase origin.
   bit m_run = 0, m_paused = 0;
   int m_step = 0, m_note = 0, m_left = 0, m_t0 = 0;
   int last_step = 0, last_note = 0;
   bit last_busy = 0, last_done = 0;

   task automatic expect_out(input int c, input int s, input int n, input bit b, input bit d);
      exp_t e;
      if (s != last_step || n != last_note || b != last_busy || d != last_done) begin
         e.cyc = c; e.step = 4'(s); e.note = 4'(n); e.busy = b; e.done = d;
         sb_q.push_back(e);
         last_step = s; last_note = n; last_busy = b; last_done = d;
      end
   endtask

   task automatic tone_at(input int c, input bit on, input int n, input int t0);
      tone_t t;
      t.cyc = c;
      t.hp  = pitch[n] >> TONE_SHIFT;
      t.on  = on && (n >= 1) && (n <= 8) && (t.hp > 0);
      t.t0  = t0;
      tl_q.push_back(t);
   endtask

   task automatic m_load(input int c);
      int old_note = m_note;
      m_note = song_note[m_step];
      m_left = song_beats[m_step];
      if (m_note != old_note) m_t0 = c;
      expect_out(c, m_step, m_note, 1'b1, 1'b0);
      tone_at(c, 1'b1, m_note, m_t0);
   endtask

   task automatic m_idle(input int c);
      m_run = 0; m_paused = 0; m_step = 0; m_note = 0;
      expect_out(c, 0, 0, 1'b0, 1'b0);
      tone_at(c, 1'b0, 0, 0);
   endtask

   task automatic m_tick(input int c);
      if (m_run && !m_paused) begin
         m_left--;
         if (m_left == 0) begin
            if (m_step < SONG_LEN - 1) begin
               m_step++;
               m_load(c);
            end else if (loop_en) begin
               m_step = 0;
               m_load(c);
            end else begin
               m_run = 0; m_step = 0; m_note = 0;
               expect_out(c, 0, 0, 1'b0, 1'b1);
               expect_out(c + 1, 0, 0, 1'b0, 1'b0);
               tone_at(c, 1'b0, 0, 0);
            end
         end
      end
   endtask

   function automatic int rl();
      if ($urandom_range(0, 9) == 0) return int'($urandom_range(200, 600));
      return int'($urandom_range(3, 30));
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // A rise driven at negedge N acts at posedge N+3 (two sync flops plus edge detect).
   task automatic op_beat(input int hi, input int lo);
      beat = 1'b1;
      m_tick(cyc + 3);
      cycles(hi);
      beat = 1'b0;
      cycles(lo);
   endtask

   task automatic op_start();
      start = 1'b1;
      if (!m_run) begin
         m_run = 1; m_paused = 0; m_step = 0;
         m_load(cyc + 1);
      end
      cycles(1);
      start = 1'b0;
      cycles(1);
   endtask

   task automatic op_stop();
      stop = 1'b1;
      if (m_run) m_idle(cyc + 1);
      cycles(1);
      stop = 1'b0;
      cycles(2);
   endtask

   task automatic op_stop_tick(input int hi, input int lo);
      beat = 1'b1;
      if (m_run) m_idle(cyc + 3);
      cycles(2);
      stop = 1'b1;
      cycles(1);
      stop = 1'b0;
      cycles(hi - 3);
      beat = 1'b0;
      cycles(lo);
   endtask

   task automatic op_start_stop();
      start = 1'b1; stop = 1'b1;
      if (m_run) m_idle(cyc + 1);
      cycles(1);
      start = 1'b0; stop = 1'b0;
      cycles(2);
   endtask

   task automatic op_pause(input int k);
      pause = 1'b1;
      if (m_run) begin
         m_paused = 1;
         tone_at(cyc + 1, 1'b0, 0, 0);
      end
      cycles(2);
      repeat (k) op_beat(rl(), rl());
      pause = 1'b0;
      if (m_run) begin
         m_paused = 0;
         m_t0 = cyc + 1;
         tone_at(cyc + 1, 1'b1, m_note, m_t0);
      end
      cycles(3);
   endtask

   task automatic op_reset();
      rst_n = 1'b0;
      m_run = 0; m_paused = 0; m_step = 0; m_note = 0;
      expect_out(cyc + 1, 0, 0, 1'b0, 1'b0);
      tone_at(cyc + 1, 1'b0, 0, 0);
      cycles(2);
      rst_n = 1'b1;
      cycles(2);
   endtask

   // Monitor: tone waveform against the model every cycle, output changes against the queue.
   logic [3:0] prev_step = 4'd0, prev_note = 4'd0;
   logic       prev_busy = 1'b0, prev_done = 1'b0;
   bit         t_on = 1'b0;
   int         t_hp = 1, t_t0 = 0, ref_a = 0, aud_bad = 0, aud_first = -1;
   tone_t      cur_t;
   exp_t       cur_e;

   always @(negedge clk) begin
      if (mon_en) begin
         while (tl_q.size() > 0) begin
            if (tl_q[0].cyc > cyc) break;
            cur_t = tl_q.pop_front();
            t_on = cur_t.on; t_hp = cur_t.hp; t_t0 = cur_t.t0;
         end
         ref_a = t_on ? (((cyc - t_t0) / t_hp) % 2) : 0;
         if (audio_o !== ref_a[0]) begin
            aud_bad++;
            if (aud_first < 0) aud_first = cyc;
         end
         while (sb_q.size() > 0) begin
            if (sb_q[0].cyc >= cyc) break;
            cur_e = sb_q.pop_front();
            n_tests++; n_fail++;
            $display("FAIL missed_change: outputs unchanged at cyc %0d, required step=%0d note=%0d busy=%0b done=%0b at cyc %0d",
                     cyc, cur_e.step, cur_e.note, cur_e.busy, cur_e.done, cur_e.cyc);
         end
         if ({step_o, note_o, busy_o, done_o} !== {prev_step, prev_note, prev_busy, prev_done}) begin
            n_tests++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_change at cyc %0d: step=%0d note=%0d busy=%0b done=%0b, required no change",
                        cyc, step_o, note_o, busy_o, done_o);
            end else begin
               cur_e = sb_q.pop_front();
               if (cur_e.cyc != cyc || step_o !== cur_e.step || note_o !== cur_e.note ||
                   busy_o !== cur_e.busy || done_o !== cur_e.done) begin
                  n_fail++;
                  $display("FAIL output_change: got step=%0d note=%0d busy=%0b done=%0b at cyc %0d, required step=%0d note=%0d busy=%0b done=%0b at cyc %0d",
                           step_o, note_o, busy_o, done_o, cyc,
                           cur_e.step, cur_e.note, cur_e.busy, cur_e.done, cur_e.cyc);
               end
            end
            n_tests++;
            if (aud_bad != 0) begin
               n_fail++;
               $display("FAIL audio_window: %0d wrong audio_out cycles (first at cyc %0d), required 0",
                        aud_bad, aud_first);
            end
            aud_bad = 0; aud_first = -1;
            prev_step = step_o; prev_note = note_o; prev_busy = busy_o; prev_done = done_o;
         end
      end
   end

   initial begin
      cycles(3);
      n_tests++;
      if ({step_o, note_o, busy_o, done_o, audio_o} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_state: got step=%0d note=%0d busy=%0b done=%0b audio=%0b, required all 0",
                  step_o, note_o, busy_o, done_o, audio_o);
      end
      rst_n  = 1'b1;
      mon_en = 1'b1;
      cycles(2);

      // Three quick beats, then long notes so the tone period is exercised.
      op_start();
      repeat (3) op_beat(20, 20);
      op_stop();
      op_start();
      cycles(1000);
      op_beat(500, 500);
      op_beat(20, 20);

      // Wrap with looping, then finish the song without it.
      loop_en = 1'b1;
      repeat (20) op_beat(rl(), rl());
      loop_en = 1'b0;
      for (int i = 0; i < 40 && m_run; i++) op_beat(rl(), rl());

      // Pause at step 5, beat 0.
      op_start();
      repeat (5) op_beat(rl(), rl());
      op_pause(5);
      op_beat(20, 20);
      op_stop();

      // Stop coinciding with a tick at step 3; start+stop while idle.
      op_start();
      repeat (3) op_beat(10, 10);
      op_stop_tick(10, 10);
      op_start_stop();

      // Reset in the middle of step 9, then replay.
      op_start();
      repeat (9) op_beat(rl(), rl());
      cycles(5);
      op_reset();
      op_start();
      repeat (2) op_beat(20, 20);

      while (cyc < 60000) begin
         int r = int'($urandom_range(0, 99));
         if (!m_run) begin
            if (r < 70) begin
               loop_en = 1'($urandom_range(0, 1));
               op_start();
            end else if (r < 80) op_start_stop();
            else if (r < 90) op_reset();
            else op_beat(rl(), rl());
         end else begin
            if (r < 70) op_beat(rl(), rl());
            else if (r < 78) op_pause(int'($urandom_range(1, 4)));
            else if (r < 82) op_stop();
            else if (r < 86) op_stop_tick(rl() + 1, rl());
            else if (r < 88) op_reset();
            else if (r < 94) begin
               loop_en = ~loop_en;
               cycles(1);
            end else op_start();
         end
      end

      cycles(10);
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL pending_changes: %0d expected output changes never seen, required 0", sb_q.size());
      end
      n_tests++;
      if (aud_bad != 0) begin
         n_fail++;
         $display("FAIL audio_tail: %0d wrong audio_out cycles (first at cyc %0d), required 0",
                  aud_bad, aud_first);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
